// File: rtl/mul_pkg.sv
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared encodings for the M-extension multiply sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic a_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
// ============================================================================
//  Module   : mul_shift_add_dp
//  Brief    : Radix-2 shift-add datapath with sign-magnitude operand capture.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [1:0]            mul_op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [CNT_W-1:0]      cnt,
    output logic [2*DATA_W-1:0]   prod_next
);

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_acc;
    logic                r_neg;

    logic                w_sign_a;
    logic                w_sign_b;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [2*DATA_W-1:0] w_partial;
    logic [2*DATA_W-1:0] w_acc_next;

    // Magnitudes are unsigned, so |-2^(DATA_W-1)| fits without overflow.
    assign w_sign_a = a_is_signed(mul_op) & operand_a[DATA_W-1];
    assign w_sign_b = b_is_signed(mul_op) & operand_b[DATA_W-1];
    assign w_abs_a  = w_sign_a ? -operand_a : operand_a;
    assign w_abs_b  = w_sign_b ? -operand_b : operand_b;

    assign w_partial  = r_mplier[0] ? ({{DATA_W{1'b0}}, r_mcand} << cnt) : '0;
    assign w_acc_next = r_acc + w_partial;
    // Product including the step being taken this cycle, so the last step retires directly.
    assign prod_next  = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
        end else if (load) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_neg    <= w_sign_a ^ w_sign_b;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
//  Module   : mul_seq_ctrl
//  Brief    : Multi-cycle MUL/MULH/MULHSU/MULHU sequencer with PC stall.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              mul_valid,
    input  logic [1:0]        mul_op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_low_half;
    logic                r_busy;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;

    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic [2*DATA_W-1:0] w_prod_next;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (enable) begin
            case (r_state)
                ST_IDLE: if (mul_valid) w_state_next = ST_CALC;
                ST_CALC: begin
                    // Losing mul_valid mid-iteration abandons the operation.
                    if (!mul_valid)                w_state_next = ST_IDLE;
                    else if (r_cnt == C_LAST_CNT)  w_state_next = ST_DONE;
                end
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall  = enable & mul_valid & (r_state != ST_DONE);
        w_load = enable & mul_valid & (r_state == ST_IDLE);
        w_step = enable & mul_valid & (r_state == ST_CALC);
        w_last = w_step & (r_cnt == C_LAST_CNT);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt          <= '0;
            r_low_half     <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_last;
            if (w_load) begin
                r_cnt      <= '0;
                r_low_half <= (mul_op == MUL_OP_MUL);
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_result <= r_low_half ? w_prod_next[DATA_W-1:0]
                                       : w_prod_next[2*DATA_W-1:DATA_W];
            end
        end
    end

    mul_shift_add_dp #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dp (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (w_load),
        .step      (w_step),
        .mul_op    (mul_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .cnt       (r_cnt),
        .prod_next (w_prod_next)
    );

    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
//  Module   : tb_mul_seq_ctrl
//  Brief    : Directed self-checking bench for mul_seq_ctrl (DATA_W = 64).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;
    import mul_pkg::*;

    localparam int W = 64;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         enable;
    logic         mul_valid;
    logic [1:0]   mul_op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         stall;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq_ctrl #(.DATA_W(W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .enable       (enable),
        .mul_valid    (mul_valid),
        .mul_op       (mul_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Issues one multiply and waits (bounded) for its retire pulse.
    task automatic run_mul(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input int gap_at, input int gap_len,
                           output logic [W-1:0] res, output int lat, output int stall_err,
                           output longint t_pulse);
        int cyc = 0;
        bit seen = 1'b0;
        stall_err = 0;
        lat = -1;
        res = '0;
        t_pulse = 0;
        @(posedge clk); #1;
        mul_valid = 1'b1; mul_op = op; operand_a = va; operand_b = vb; enable = 1'b1;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                seen = 1'b1; lat = cyc; res = result; t_pulse = longint'($time);
                if (stall !== 1'b0) stall_err++;
            end else if (stall !== enable) begin
                stall_err++;
            end
            if (!seen) begin
                @(posedge clk); #1;
                cyc++;
                enable = !(cyc >= gap_at && cyc < gap_at + gap_len);
                operand_a = ~va;
                operand_b = ~vb;
            end
        end
    endtask

    task automatic finish_idle(input string name);
        @(posedge clk); #1;
        mul_valid = 1'b0;
        @(negedge clk);
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic watch_no_pulse(input string name, input int ncyc);
        int pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) pulses++;
        end
        check(name, 64'(pulses), 64'd0);
    endtask

    initial begin
        vec_t         vecs[14];
        logic [W-1:0] res;
        int           lat;
        int           serr;
        longint       t1;
        longint       t2;

        vecs[0]  = '{MUL_OP_MUL,    64'd3,                   64'd5,                   64'd15};
        vecs[1]  = '{MUL_OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[3]  = '{MUL_OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[4]  = '{MUL_OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{MUL_OP_MULH,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[6]  = '{MUL_OP_MUL,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[7]  = '{MUL_OP_MULHU,  64'h8000_0000_0000_0000, 64'd2,                   64'd1};
        vecs[8]  = '{MUL_OP_MULH,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                   64'hFFFF_FFFF_FFFF_FFF1};
        vecs[10] = '{MUL_OP_MULH,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{MUL_OP_MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[12] = '{MUL_OP_MUL,    64'd0,                   64'd0,                   64'd0};
        vecs[13] = '{MUL_OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};

        arst_n = 1'b0; enable = 1'b0; mul_valid = 1'b0; mul_op = 2'b00;
        operand_a = '0; operand_b = '0;

        #12;
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_result", result,            64'd0);
        check("rst_rvalid", 64'(result_valid), 64'd0);
        check("rst_stall_disabled", 64'(stall), 64'd0);
        enable = 1'b1; mul_valid = 1'b1; #1;
        check("rst_stall_idle", 64'(stall), 64'd1);
        mul_valid = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_mul(vecs[i].op, vecs[i].a, vecs[i].b, -1, 0, res, lat, serr, t1);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd65);
            check($sformatf("vec%0d_stall", i), 64'(serr), 64'd0);
            finish_idle($sformatf("vec%0d_busy_after", i));
        end

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        mul_valid = 1'b1; mul_op = MUL_OP_MUL; operand_a = 64'd3; operand_b = 64'd5;
        repeat (20) @(posedge clk);
        #1;
        check("midcalc_busy_before", 64'(busy), 64'd1);
        arst_n = 1'b0; mul_valid = 1'b0;
        #1;
        check("midcalc_rst_busy",   64'(busy),         64'd0);
        check("midcalc_rst_result", result,            64'd0);
        check("midcalc_rst_rvalid", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        watch_no_pulse("midcalc_no_pulse", 80);
        run_mul(MUL_OP_MUL, 64'd7, 64'd6, -1, 0, res, lat, serr, t1);
        check("after_rst_result",  res,      64'd42);
        check("after_rst_latency", 64'(lat), 64'd65);
        finish_idle("after_rst_busy");

        // Ten disabled cycles mid-CALC stretch latency by exactly ten.
        run_mul(MUL_OP_MULHU, 64'h0000_0001_0000_0000, 64'h0000_0100_0000_0000, 30, 10,
                res, lat, serr, t1);
        check("gap_result",  res,       64'h100);
        check("gap_latency", 64'(lat),  64'd75);
        check("gap_stall",   64'(serr), 64'd0);
        finish_idle("gap_busy_after");

        // Abort: mul_valid dropped during CALC.
        @(posedge clk); #1;
        mul_valid = 1'b1; mul_op = MUL_OP_MUL; operand_a = 64'd3; operand_b = 64'd5;
        repeat (10) @(posedge clk);
        #1;
        mul_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        watch_no_pulse("abort_no_pulse", 70);

        // Back-to-back multiplies.
        run_mul(MUL_OP_MUL, 64'd3, 64'd5, -1, 0, res, lat, serr, t1);
        check("b2b_first_result", res, 64'd15);
        run_mul(MUL_OP_MUL, 64'd7, 64'd6, -1, 0, res, lat, serr, t2);
        check("b2b_second_result", res, 64'd42);
        check("b2b_pulse_spacing", 64'((t2 - t1) / 10), 64'd66);
        finish_idle("b2b_busy_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
